// File: rtl/music_pkg.sv
// music_pkg: shared note/duration widths, scheduler queue entry and scheduler FSM states.
// Contents:
//   NOTE_W, DUR_W   widths of the note index and the duration in beats
//   sched_entry_t   queued entry {is_barrier, note, duration}
//   sched_state_t   IDLE / DISPATCH / BARRIER_WAIT
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    typedef struct packed {
        logic              is_barrier;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } sched_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        BARRIER_WAIT
    } sched_state_t;

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: synchronous FIFO of entry_t that accepts up to two pushes per cycle.
// Ports:
//   i_clk, i_reset           clock; synchronous active-low reset (empties the FIFO)
//   i_push_a, i_data_a       first entry pushed this cycle
//   i_push_b, i_data_b       second entry, written behind entry a (only valid with i_push_a)
//   i_pop                    discard the head entry
//   o_head                   entry at the head
//   o_full, o_empty, o_count occupancy
// The caller guarantees that pushes never exceed the free space (counting this cycle's pop).
module sched_fifo
    import music_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = sched_entry_t
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push_a,
    input  entry_t                 i_data_a,
    input  logic                   i_push_b,
    input  entry_t                 i_data_b,
    input  logic                   i_pop,
    output entry_t                 o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_wp_b;

    assign w_wp_b  = r_wp + AW'(i_push_a);
    assign o_head  = r_mem[r_rp];
    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;

    always_ff @(posedge i_clk) begin
        if (i_push_a) r_mem[r_wp] <= i_data_a;
        if (i_push_b) r_mem[w_wp_b] <= i_data_b;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + AW'(i_push_a) + AW'(i_push_b);
            r_rp    <= r_rp + AW'(i_pop);
            r_count <= r_count + (AW+1)'(i_push_a) + (AW+1)'(i_push_b) - (AW+1)'(i_pop);
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: queues notes/barriers from the song reader and loads them round-robin onto free voices.
// Ports:
//   i_clk, i_reset                   clock; synchronous active-low reset
//   i_play_enable                    dispatch (and any pop) allowed when high
//   i_new_note, i_note, i_duration   push a note entry
//   i_advance                        push a barrier entry (behind a same-cycle note)
//   i_voice_done                     per-voice completion pulse, clears busy
//   o_note_ready                     FIFO not full
//   o_voice_load, o_voice_note,
//   o_voice_duration                 registered one-cycle load pulse with its note/duration
//   o_voice_busy                     registered occupancy flags
//   o_all_idle                       nothing queued and no voice occupied
//   o_overflow                       sticky: an entry was dropped
// Build option VOICE_SCHED_STATS_EN adds o_dispatch_count (wrapping) and o_drop_count (saturating).
module voice_scheduler
    import music_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_play_enable,
    input  logic                  i_new_note,
    input  logic [NOTE_W-1:0]     i_note,
    input  logic [DUR_W-1:0]      i_duration,
    input  logic                  i_advance,
    input  logic [NUM_VOICES-1:0] i_voice_done,
    output logic                  o_note_ready,
    output logic [NUM_VOICES-1:0] o_voice_load,
    output logic [NOTE_W-1:0]     o_voice_note,
    output logic [DUR_W-1:0]      o_voice_duration,
    output logic [NUM_VOICES-1:0] o_voice_busy,
    output logic                  o_all_idle,
    output logic                  o_overflow
`ifdef VOICE_SCHED_STATS_EN
    ,
    output logic [15:0]           o_dispatch_count,
    output logic [7:0]            o_drop_count
`endif
);

    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // First free voice at or after rr, wrapping; returns {found, index}.
    function automatic logic [VW:0] pick_voice(input logic [NUM_VOICES-1:0] occ, input logic [VW-1:0] rr);
        logic [VW:0] sel;
        int          j;
        sel = '0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NUM_VOICES) j = j - NUM_VOICES;
            if (!occ[j]) sel = {1'b1, VW'(j)};
        end
        return sel;
    endfunction

    sched_state_t          r_state;
    logic [VW-1:0]         r_rr;
    logic [NUM_VOICES-1:0] r_voice_load;
    logic [NUM_VOICES-1:0] r_busy;
    logic [NOTE_W-1:0]     r_voice_note;
    logic [DUR_W-1:0]      r_voice_duration;
    logic                  r_overflow;

    sched_entry_t          w_head;
    sched_entry_t          w_in_note;
    sched_entry_t          w_in_bar;
    sched_entry_t          w_disp;
    sched_state_t          w_next;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    logic [CW-1:0]         w_cnt_next;
    logic [NUM_VOICES-1:0] w_occ;
    logic [VW:0]           w_pick;
    logic [VW-1:0]         w_sel;
    logic                  w_bypass;
    logic                  w_can;
    logic                  w_pop_bar;
    logic                  w_pop_note;
    logic                  w_pop;
    logic                  w_dispatch;
    logic                  w_push_note;
    logic                  w_push_bar;
    logic                  w_push_a;
    logic                  w_push_b;
    logic [1:0]            w_drops;

    // A voice whose load pulse is on the outputs has no busy flag yet, so it counts as occupied.
    always_comb begin
        w_occ      = r_busy | r_voice_load;
        w_pick     = pick_voice(w_occ, r_rr);
        w_sel      = w_pick[VW-1:0];
        w_in_note  = {1'b0, i_note, i_duration};
        w_in_bar   = {1'b1, {NOTE_W{1'b0}}, {DUR_W{1'b0}}};
        // An arriving note with nothing queued goes straight to a voice, skipping the FIFO.
        w_bypass   = r_state == IDLE && w_empty && i_new_note && i_play_enable && w_pick[VW];
        w_can      = i_play_enable && !w_empty &&
                     (r_state == DISPATCH || (r_state == BARRIER_WAIT && w_occ == '0));
        w_pop_bar  = w_can && w_head.is_barrier;
        w_pop_note = w_can && !w_head.is_barrier && w_pick[VW];
        w_pop      = w_pop_bar || w_pop_note;
        w_dispatch = w_bypass || w_pop_note;
        w_disp     = w_bypass ? w_in_note : w_head;
        // A same-cycle pop frees its slot for this cycle's pushes.
        w_free      = CW'(FIFO_DEPTH) - w_count + CW'(w_pop);
        w_push_note = i_new_note && !w_bypass && w_free != '0;
        w_push_bar  = i_advance && (w_push_note ? w_free >= CW'(2) : w_free != '0);
        w_push_a    = w_push_note || w_push_bar;
        w_push_b    = w_push_note && w_push_bar;
        w_drops     = 2'(i_new_note && !w_bypass && !w_push_note) + 2'(i_advance && !w_push_bar);
        w_cnt_next  = w_count + CW'(w_push_a) + CW'(w_push_b) - CW'(w_pop);
        w_next      = w_pop_bar ? BARRIER_WAIT :
                      (r_state == BARRIER_WAIT && w_occ != '0) ? BARRIER_WAIT :
                      (w_cnt_next == '0) ? IDLE : DISPATCH;
    end

    sched_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (sched_entry_t)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push_a (w_push_a),
        .i_data_a (w_push_note ? w_in_note : w_in_bar),
        .i_push_b (w_push_b),
        .i_data_b (w_in_bar),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

`ifdef VOICE_SCHED_STATS_EN
    logic [15:0] r_dispatch_count;
    logic [7:0]  r_drop_count;
    logic [8:0]  w_drop_sum;

    assign w_drop_sum       = {1'b0, r_drop_count} + 9'(w_drops);
    assign o_dispatch_count = r_dispatch_count;
    assign o_drop_count     = r_drop_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_dispatch_count <= '0;
            r_drop_count     <= '0;
        end else begin
            r_dispatch_count <= r_dispatch_count + 16'(w_dispatch);
            r_drop_count     <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state          <= IDLE;
            r_rr             <= '0;
            r_voice_load     <= '0;
            r_busy           <= '0;
            r_voice_note     <= '0;
            r_voice_duration <= '0;
            r_overflow       <= 1'b0;
        end else begin
            r_state          <= w_next;
            r_busy           <= (r_busy | r_voice_load) & ~i_voice_done;
            r_voice_load     <= w_dispatch ? NUM_VOICES'(1'b1) << w_sel : '0;
            r_voice_note     <= w_dispatch ? w_disp.note : '0;
            r_voice_duration <= w_dispatch ? w_disp.duration : '0;
            if (w_dispatch) r_rr <= (w_sel == VW'(NUM_VOICES - 1)) ? '0 : w_sel + 1'b1;
            if (w_drops != '0) r_overflow <= 1'b1;
        end
    end

    assign o_note_ready     = !w_full;
    assign o_voice_load     = r_voice_load;
    assign o_voice_note     = r_voice_note;
    assign o_voice_duration = r_voice_duration;
    assign o_voice_busy     = r_busy;
    assign o_all_idle       = w_empty && w_occ == '0;
    assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed self-checking bench for voice_scheduler (3 voices, 4-entry FIFO).
module tb_voice_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       play_enable;
    logic       new_note;
    logic [5:0] note;
    logic [5:0] duration;
    logic       advance;
    logic [2:0] voice_done;
    logic       note_ready;
    logic [2:0] voice_load;
    logic [5:0] voice_note;
    logic [5:0] voice_duration;
    logic [2:0] voice_busy;
    logic       all_idle;
    logic       overflow;
`ifdef VOICE_SCHED_STATS_EN
    logic [15:0] dispatch_count;
    logic [7:0]  drop_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_scheduler #(
        .NUM_VOICES (3),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset_n),
        .i_play_enable    (play_enable),
        .i_new_note       (new_note),
        .i_note           (note),
        .i_duration       (duration),
        .i_advance        (advance),
        .i_voice_done     (voice_done),
        .o_note_ready     (note_ready),
        .o_voice_load     (voice_load),
        .o_voice_note     (voice_note),
        .o_voice_duration (voice_duration),
        .o_voice_busy     (voice_busy),
        .o_all_idle       (all_idle),
        .o_overflow       (overflow)
`ifdef VOICE_SCHED_STATS_EN
        ,
        .o_dispatch_count (dispatch_count),
        .o_drop_count     (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then return 1 time unit after it.
    task automatic cyc(input logic nn, input logic [5:0] n, input logic [5:0] d,
                       input logic adv, input logic [2:0] dn);
        new_note   = nn;
        note       = n;
        duration   = d;
        advance    = adv;
        voice_done = dn;
        @(posedge clk);
        #1;
        new_note   = 1'b0;
        advance    = 1'b0;
        voice_done = 3'b000;
    endtask

    task automatic idle();
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 3'b000);
    endtask

    task automatic push(input logic [5:0] n, input logic [5:0] d);
        cyc(1'b1, n, d, 1'b0, 3'b000);
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".load"}, 32'(voice_load), 32'd0);
        chk({t, ".note"}, 32'(voice_note), 32'd0);
        chk({t, ".dur"}, 32'(voice_duration), 32'd0);
        chk({t, ".busy"}, 32'(voice_busy), 32'd0);
        chk({t, ".ovf"}, 32'(overflow), 32'd0);
        chk({t, ".ready"}, 32'(note_ready), 32'd1);
        chk({t, ".idle"}, 32'(all_idle), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        play_enable = 1'b1;
        new_note    = 1'b0;
        note        = '0;
        duration    = '0;
        advance     = 1'b0;
        voice_done  = '0;
        idle();
        chk_reset("rst");
`ifdef VOICE_SCHED_STATS_EN
        chk("rst.dispatch_cnt", 32'(dispatch_count), 32'd0);
        chk("rst.drop_cnt", 32'(drop_count), 32'd0);
`endif
        reset_n = 1'b1;

        // single note: load next cycle, busy one cycle after the load
        push(6'd12, 6'd4);
        chk("t1.load", 32'(voice_load), 32'b001);
        chk("t1.note", 32'(voice_note), 32'd12);
        chk("t1.dur", 32'(voice_duration), 32'd4);
        chk("t1.busy0", 32'(voice_busy), 32'b000);
        idle();
        chk("t1.load_end", 32'(voice_load), 32'b000);
        chk("t1.busy1", 32'(voice_busy), 32'b001);
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 3'b001);
        chk("t1.busy_clr", 32'(voice_busy), 32'b000);
        chk("t1.idle", 32'(all_idle), 32'd1);
        do_reset();

        // four notes, round robin 0,1,2, fourth waits for a done
        push(6'd1, 6'd5);
        chk("t2.load_a", 32'(voice_load), 32'b001);
        push(6'd2, 6'd5);
        chk("t2.load_b", 32'(voice_load), 32'b010);
        chk("t2.note_b", 32'(voice_note), 32'd2);
        push(6'd3, 6'd5);
        chk("t2.load_c", 32'(voice_load), 32'b100);
        push(6'd4, 6'd5);
        chk("t2.load_d_held", 32'(voice_load), 32'b000);
        idle();
        chk("t2.busy_all", 32'(voice_busy), 32'b111);
        chk("t2.not_idle", 32'(all_idle), 32'd0);
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 3'b010);
        chk("t2.load_d_n1", 32'(voice_load), 32'b000);
        chk("t2.busy_after_done", 32'(voice_busy), 32'b101);
        idle();
        chk("t2.load_d", 32'(voice_load), 32'b010);
        chk("t2.note_d", 32'(voice_note), 32'd4);
        do_reset();

        // barrier: C waits until every voice has finished
        push(6'd10, 6'd1);
        chk("t3.load_a", 32'(voice_load), 32'b001);
        push(6'd11, 6'd1);
        chk("t3.load_b", 32'(voice_load), 32'b010);
        cyc(1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
        chk("t3.adv", 32'(voice_load), 32'b000);
        push(6'd13, 6'd7);
        chk("t3.c_held0", 32'(voice_load), 32'b000);
        idle();
        chk("t3.c_held1", 32'(voice_load), 32'b000);
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 3'b001);
        chk("t3.c_held2", 32'(voice_load), 32'b000);
        idle();
        chk("t3.c_held3", 32'(voice_load), 32'b000);
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 3'b010);
        chk("t3.c_held_n1", 32'(voice_load), 32'b000);
        chk("t3.busy_zero", 32'(voice_busy), 32'b000);
        idle();
        chk("t3.load_c", 32'(voice_load), 32'b100);
        chk("t3.note_c", 32'(voice_note), 32'd13);
        chk("t3.dur_c", 32'(voice_duration), 32'd7);
        do_reset();

        // fill while all voices busy; push+pop on a full FIFO; then overflow
        push(6'd30, 6'd2);
        push(6'd31, 6'd2);
        push(6'd32, 6'd2);
        push(6'd33, 6'd2);
        push(6'd34, 6'd2);
        push(6'd35, 6'd2);
        chk("t4.ready_3", 32'(note_ready), 32'd1);
        push(6'd36, 6'd2);
        chk("t4.ready_full", 32'(note_ready), 32'd0);
        chk("t4.ovf_full", 32'(overflow), 32'd0);
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 3'b001);
        chk("t4.done_noload", 32'(voice_load), 32'b000);
        push(6'd37, 6'd2);
        chk("t4.pp_load", 32'(voice_load), 32'b001);
        chk("t4.pp_note", 32'(voice_note), 32'd33);
        chk("t4.pp_ovf", 32'(overflow), 32'd0);
        chk("t4.pp_ready", 32'(note_ready), 32'd0);
        push(6'd38, 6'd2);
        chk("t4.ovf", 32'(overflow), 32'd1);
        chk("t4.ready_still", 32'(note_ready), 32'd0);
`ifdef VOICE_SCHED_STATS_EN
        chk("t4.drop_cnt", 32'(drop_count), 32'd1);
        chk("t4.dispatch_cnt", 32'(dispatch_count), 32'd4);
`endif
        idle();
        idle();
        chk("t4.ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        chk("t4.ovf_rst", 32'(overflow), 32'd0);

        // note+advance with one free slot: note kept, barrier dropped
        push(6'd40, 6'd1);
        push(6'd41, 6'd1);
        push(6'd42, 6'd1);
        push(6'd43, 6'd1);
        push(6'd44, 6'd1);
        push(6'd45, 6'd1);
        chk("t7.ovf0", 32'(overflow), 32'd0);
        cyc(1'b1, 6'd46, 6'd1, 1'b1, 3'b000);
        chk("t7.ready", 32'(note_ready), 32'd0);
        chk("t7.ovf", 32'(overflow), 32'd1);
        do_reset();

        // play_enable low holds the queue
        play_enable = 1'b0;
        push(6'd20, 6'd3);
        chk("t5.hold0", 32'(voice_load), 32'b000);
        push(6'd21, 6'd3);
        chk("t5.hold1", 32'(voice_load), 32'b000);
        idle();
        chk("t5.hold2", 32'(voice_load), 32'b000);
        play_enable = 1'b1;
        idle();
        chk("t5.load0", 32'(voice_load), 32'b001);
        chk("t5.note0", 32'(voice_note), 32'd20);
        idle();
        chk("t5.load1", 32'(voice_load), 32'b010);
        chk("t5.note1", 32'(voice_note), 32'd21);
        idle();
        chk("t5.load_end", 32'(voice_load), 32'b000);
        do_reset();

        // reset during a barrier wait with three entries queued
        push(6'd50, 6'd1);
        push(6'd51, 6'd1);
        cyc(1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
        push(6'd52, 6'd1);
        push(6'd53, 6'd1);
        push(6'd54, 6'd1);
        chk("t6.queued_idle", 32'(all_idle), 32'd0);
        chk("t6.queued_busy", 32'(voice_busy), 32'b011);
        reset_n = 1'b0;
        idle();
        chk_reset("t6");
        reset_n = 1'b1;
        idle();
        chk("t6.discarded", 32'(voice_load), 32'b000);
        chk("t6.still_idle", 32'(all_idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
